// File: rtl/anton_neopixel_sequencer_pkg.sv
// Shared definitions for the NeoPixel output path: state encoding, buffer and
// latch-period defaults, and a constant log2 helper for port widths.
package anton_neopixel_sequencer_pkg;

    typedef enum logic {
        ENUM_STATE_RESET    = 1'b0,
        ENUM_STATE_TRANSMIT = 1'b1
    } seqStateT;

    localparam int unsigned BUFFER_END_DEFAULT  = 47;
    localparam int unsigned RESET_DELAY_DEFAULT = 400;

    // Bits needed to count 0..value-1; never returns less than 1.
    function automatic int unsigned CLOG2(input int unsigned value);
        int unsigned result;
        int unsigned remaining;
        result    = 0;
        remaining = (value > 0) ? value - 1 : 0;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/anton_neopixel_sequencer.sv
// Pattern-slot sequencer for the NeoPixel stream encoder: walks the pixel buffer
// one slot per clock and holds the line low for the latch period between frames.
module anton_neopixel_sequencer
    import anton_neopixel_sequencer_pkg::*;
#(
    parameter int unsigned BUFFER_END  = BUFFER_END_DEFAULT,
    parameter int unsigned RESET_DELAY = RESET_DELAY_DEFAULT,
    localparam int unsigned BUFFER_BITS = CLOG2(BUFFER_END + 1),
    localparam int unsigned DELAY_BITS  = CLOG2(RESET_DELAY + 1)
) (
    input  logic                   clk6mhz,
    input  logic                   syncReset,
    input  logic                   regCtrlRun,
    input  logic                   regCtrlLoop,
    input  logic                   regCtrl32bit,
    input  logic [BUFFER_BITS-1:0] regMax,
    output logic                   state,
    output logic [BUFFER_BITS-1:0] pixelIndex,
    output logic [4:0]             pixelBitIndex,
    output logic [2:0]             bitPatternIndex,
    output logic                   streamSyncOf
);

    localparam int unsigned PIXEL_HI_BITS = BUFFER_BITS - 2;

    seqStateT stateReg;
    seqStateT stateNext;

    logic [DELAY_BITS-1:0]  delayCount;
    logic [BUFFER_BITS-1:0] maxLatched;
    logic                   mode32Latched;
    logic                   loopLatched;
    logic                   holdOff;

    logic delaySat;
    logic lastPixel;
    logic frameEnd;
    logic startFrame;
    logic stopFrame;

    assign state     = 1'(stateReg);
    assign delaySat  = (delayCount == DELAY_BITS'(RESET_DELAY - 1));
    assign lastPixel = mode32Latched
                     ? (pixelIndex[BUFFER_BITS-1:2] >= maxLatched[BUFFER_BITS-1:2])
                     : (pixelIndex >= maxLatched);
    assign frameEnd  = (bitPatternIndex == 3'd7) && (pixelBitIndex == 5'd23) && lastPixel;

    always_ff @(posedge clk6mhz) begin
        if (syncReset) begin
            stateReg <= ENUM_STATE_RESET;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        startFrame = 1'b0;
        stopFrame  = 1'b0;
        case (stateReg)
            ENUM_STATE_RESET: begin
                if (delaySat && regCtrlRun && !holdOff) begin
                    stateNext  = ENUM_STATE_TRANSMIT;
                    startFrame = 1'b1;
                end
            end
            ENUM_STATE_TRANSMIT: begin
                if (!regCtrlRun || frameEnd) begin
                    stateNext = ENUM_STATE_RESET;
                    stopFrame = 1'b1;
                end
            end
            default: stateNext = ENUM_STATE_RESET;
        endcase
    end

    // Index chain, latch-period counter and per-frame configuration.
    always_ff @(posedge clk6mhz) begin
        if (syncReset) begin
            pixelIndex      <= '0;
            pixelBitIndex   <= '0;
            bitPatternIndex <= '0;
            delayCount      <= '0;
            streamSyncOf    <= 1'b0;
            maxLatched      <= '0;
            mode32Latched   <= 1'b0;
            loopLatched     <= 1'b0;
            holdOff         <= 1'b0;
        end else begin
            streamSyncOf <= 1'b0;
            if (startFrame) begin
                maxLatched      <= (regMax > BUFFER_BITS'(BUFFER_END))
                                 ? BUFFER_BITS'(BUFFER_END) : regMax;
                mode32Latched   <= regCtrl32bit;
                loopLatched     <= regCtrlLoop;
                pixelIndex      <= '0;
                pixelBitIndex   <= '0;
                bitPatternIndex <= '0;
                delayCount      <= '0;
            end else if (stopFrame) begin
                pixelIndex      <= '0;
                pixelBitIndex   <= '0;
                bitPatternIndex <= '0;
                delayCount      <= '0;
                // A completed one-shot frame waits for software to cycle run.
                if (frameEnd && !loopLatched) begin
                    holdOff <= 1'b1;
                end
            end else if (stateReg == ENUM_STATE_RESET) begin
                if (!delaySat) begin
                    delayCount <= delayCount + DELAY_BITS'(1);
                end
                if (!regCtrlRun) begin
                    holdOff <= 1'b0;
                end
            end else begin
                // Raise the sync pulse so it coincides with the final slot.
                streamSyncOf <= (bitPatternIndex == 3'd6) && (pixelBitIndex == 5'd23) && lastPixel;
                if (bitPatternIndex == 3'd7) begin
                    bitPatternIndex <= '0;
                    if (pixelBitIndex == 5'd23) begin
                        pixelBitIndex <= '0;
                        if (mode32Latched) begin
                            pixelIndex <= {pixelIndex[BUFFER_BITS-1:2] + PIXEL_HI_BITS'(1), 2'b00};
                        end else begin
                            pixelIndex <= pixelIndex + BUFFER_BITS'(1);
                        end
                    end else begin
                        pixelBitIndex <= pixelBitIndex + 5'd1;
                    end
                end else begin
                    bitPatternIndex <= bitPatternIndex + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_anton_neopixel_sequencer.sv
// Bench for anton_neopixel_sequencer: a frame monitor scores each frame against
// expectations queued when the stimulus starts it.
module tb_anton_neopixel_sequencer;

    localparam int BB = 6;

    logic          clk6mhz;
    logic          syncReset;
    logic          regCtrlRun;
    logic          regCtrlLoop;
    logic          regCtrl32bit;
    logic [BB-1:0] regMax;
    logic          state;
    logic [BB-1:0] pixelIndex;
    logic [4:0]    pixelBitIndex;
    logic [2:0]    bitPatternIndex;
    logic          streamSyncOf;

    anton_neopixel_sequencer dut (
        .clk6mhz        (clk6mhz),
        .syncReset      (syncReset),
        .regCtrlRun     (regCtrlRun),
        .regCtrlLoop    (regCtrlLoop),
        .regCtrl32bit   (regCtrl32bit),
        .regMax         (regMax),
        .state          (state),
        .pixelIndex     (pixelIndex),
        .pixelBitIndex  (pixelBitIndex),
        .bitPatternIndex(bitPatternIndex),
        .streamSyncOf   (streamSyncOf)
    );

    initial begin
        clk6mhz = 1'b0;
        forever #5 clk6mhz = ~clk6mhz;
    end

    typedef struct {
        int len;
        int syncs;
        int last;
        int step;
        int gap;
    } frameExpT;

    typedef struct {
        bit mode32;
        int regMax;
        int expLen;
        int expLast;
        int expStep;
    } vecT;

    frameExpT expQ[$];
    vecT      vecs[7];

    int checks;
    int errors;
    int framesDone;
    int stray;
    int resetRun;
    int gapObs;
    int fLen, fSyncs, fSyncPos, fPrevPix, fStepOk, fAlignBad, fFirstOk, curStep;
    bit prevTx;
    int n;
    int txSeen;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    task endFrame();
        frameExpT e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got frame of %0d clocks expected none", fLen);
        end else begin
            e = expQ.pop_front();
            check("frame_len", fLen, e.len);
            check("sync_count", fSyncs, e.syncs);
            if (e.syncs > 0) check("sync_pos", fSyncPos, e.len - 1);
            check("last_pixel", fPrevPix, e.last);
            check("pixel_step_ok", fStepOk, 1);
            check("pixel_align_bad", fAlignBad, 0);
            check("first_idx_zero", fFirstOk, 1);
            if (e.gap >= 0) check("reset_gap", gapObs, e.gap);
        end
        framesDone++;
    endtask

    // Frame monitor: samples on the falling edge, scores when each frame closes.
    always @(negedge clk6mhz) begin
        if (syncReset) begin
            prevTx   = 1'b0;
            resetRun = 0;
        end else if (state) begin
            if (!prevTx) begin
                fLen      = 0;
                fSyncs    = 0;
                fSyncPos  = -1;
                fStepOk   = 1;
                fAlignBad = 0;
                fPrevPix  = int'(pixelIndex);
                gapObs    = resetRun;
                fFirstOk  = (pixelIndex == 0 && pixelBitIndex == 0 && bitPatternIndex == 0) ? 1 : 0;
                curStep   = (expQ.size() > 0) ? expQ[0].step : 1;
            end else if (int'(pixelIndex) != fPrevPix) begin
                if (int'(pixelIndex) != fPrevPix + curStep) fStepOk = 0;
                fPrevPix = int'(pixelIndex);
            end
            if (curStep == 4 && pixelIndex[1:0] != 2'b00) fAlignBad++;
            if (streamSyncOf) begin
                fSyncs++;
                fSyncPos = fLen;
            end
            fLen++;
            resetRun = 0;
            prevTx   = 1'b1;
        end else begin
            if (prevTx) endFrame();
            prevTx = 1'b0;
            resetRun++;
            if (streamSyncOf) stray++;
        end
    end

    task automatic waitFrames(input int target, input int budget);
        int k;
        k = 0;
        while (framesDone < target && k < budget) begin
            @(negedge clk6mhz);
            k++;
        end
        if (framesDone < target) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d frames expected %0d", framesDone, target);
        end
    endtask

    task automatic countToTransmit(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk6mhz);
            #1;
            cnt++;
        end while (!state && cnt < 1000);
    endtask

    initial begin
        checks = 0; errors = 0; framesDone = 0; stray = 0;
        resetRun = 0; prevTx = 1'b0; curStep = 1;
        syncReset = 1'b1; regCtrlRun = 1'b0; regCtrlLoop = 1'b0;
        regCtrl32bit = 1'b0; regMax = '0;

        vecs[0] = '{1'b0, 2,  576,  2,  1};
        vecs[1] = '{1'b1, 11, 576,  8,  4};
        vecs[2] = '{1'b0, 0,  192,  0,  1};
        vecs[3] = '{1'b1, 3,  192,  0,  4};
        vecs[4] = '{1'b1, 52, 2304, 44, 4};
        vecs[5] = '{1'b0, 5,  1152, 5,  1};
        vecs[6] = '{1'b0, 60, 9216, 47, 1};

        repeat (4) @(negedge clk6mhz);
        check("rst_state", int'(state), 0);
        check("rst_pixel", int'(pixelIndex), 0);
        check("rst_bit", int'(pixelBitIndex), 0);
        check("rst_slot", int'(bitPatternIndex), 0);
        check("rst_sync", int'(streamSyncOf), 0);

        // Reset release with run held high: first frame after the latch period.
        regCtrlRun = 1'b1;
        expQ.push_back('{192, 1, 0, 1, -1});
        syncReset = 1'b0;
        countToTransmit(n);
        check("reset_to_transmit", n, 400);
        check("start_pixel", int'(pixelIndex), 0);
        check("start_bit", int'(pixelBitIndex), 0);
        check("start_slot", int'(bitPatternIndex), 0);
        waitFrames(1, 1000);

        // One-shot frame must not restart while run stays high.
        txSeen = 0;
        repeat (700) begin
            @(negedge clk6mhz);
            if (state) txSeen++;
        end
        check("oneshot_no_rearm", txSeen, 0);
        regCtrlRun = 1'b0;
        @(negedge clk6mhz);

        for (int i = 0; i < 7; i++) begin
            regCtrl32bit = vecs[i].mode32;
            regMax       = BB'(vecs[i].regMax);
            expQ.push_back('{vecs[i].expLen, 1, vecs[i].expLast, vecs[i].expStep, -1});
            regCtrlRun = 1'b1;
            waitFrames(framesDone + 1, vecs[i].expLen + 1000);
            regCtrlRun = 1'b0;
            @(negedge clk6mhz);
        end

        // Looping single-pixel frames separated by exactly the latch period.
        regCtrl32bit = 1'b0; regMax = '0; regCtrlLoop = 1'b1;
        expQ.push_back('{192, 1, 0, 1, -1});
        expQ.push_back('{192, 1, 0, 1, 400});
        expQ.push_back('{192, 1, 0, 1, 400});
        regCtrlRun = 1'b1;
        waitFrames(framesDone + 3, 3000);
        regCtrlRun = 1'b0; regCtrlLoop = 1'b0;
        @(negedge clk6mhz);

        // Abort at pixel 1 bit 5, then restart only after a full latch period.
        regMax = BB'(2);
        expQ.push_back('{233, 0, 1, 1, -1});
        regCtrlRun = 1'b1;
        n = 0;
        while (!(state && pixelIndex == BB'(1) && pixelBitIndex == 5'd5) && n < 2000) begin
            @(negedge clk6mhz);
            n++;
        end
        regCtrlRun = 1'b0;
        @(negedge clk6mhz);
        check("abort_state", int'(state), 0);
        check("abort_no_sync", int'(streamSyncOf), 0);
        expQ.push_back('{576, 1, 2, 1, 400});
        regCtrlRun = 1'b1;
        countToTransmit(n);
        check("abort_restart_delay", n, 400);
        waitFrames(framesDone + 1, 1000);
        regCtrlRun = 1'b0;
        @(negedge clk6mhz);

        // Register changes mid-frame do not alter the frame in flight.
        regMax = BB'(2); regCtrl32bit = 1'b0;
        expQ.push_back('{576, 1, 2, 1, -1});
        regCtrlRun = 1'b1;
        n = 0;
        while (!(state && pixelIndex == BB'(1)) && n < 2000) begin
            @(negedge clk6mhz);
            n++;
        end
        regMax = '0; regCtrl32bit = 1'b1;
        waitFrames(framesDone + 1, 1000);
        regCtrlRun = 1'b0; regCtrl32bit = 1'b0;
        @(negedge clk6mhz);

        // Synchronous reset in the middle of a frame.
        regMax = BB'(2);
        regCtrlRun = 1'b1;
        n = 0;
        while (!(state && pixelIndex == BB'(1)) && n < 2000) begin
            @(negedge clk6mhz);
            n++;
        end
        syncReset = 1'b1;
        @(negedge clk6mhz);
        check("midrst_state", int'(state), 0);
        check("midrst_pixel", int'(pixelIndex), 0);
        check("midrst_bit", int'(pixelBitIndex), 0);
        check("midrst_slot", int'(bitPatternIndex), 0);
        check("midrst_sync", int'(streamSyncOf), 0);
        @(negedge clk6mhz);
        syncReset = 1'b0; regCtrlRun = 1'b0;
        repeat (3) @(negedge clk6mhz);

        check("queue_empty", expQ.size(), 0);
        check("stray_sync", stray, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/anton_neopixel_sequencer.md
# anton_neopixel_sequencer

Timing sequencer for the NeoPixel output path. It generates `state`, `pixelIndex`, `pixelBitIndex` and `bitPatternIndex`, which drive the combinational stream encoder. It walks the pixel buffer bit by bit, one pattern slot per clock, and inserts the mandatory low latch/reset period between frames. It sits between the register block (run, 32-bit mode, loop, pixel-count registers) and the stream encoder.

## Interface
Parameters:
- `BUFFER_END`, default `BUFFER_END_DEFAULT`: last valid byte address of the pixel buffer.
- `RESET_DELAY`, default `RESET_DELAY_DEFAULT` (400): number of clocks the line is held low between frames; at 6.4 MHz this is 62.5 µs.
- `BUFFER_BITS` (local), `CLOG2(BUFFER_END+1)`: pixel index width.
- `DELAY_BITS` (local), `CLOG2(RESET_DELAY+1)`: reset counter width.

Ports:
- `clk6mhz`, input, 1: single clock. One tick equals one pattern slot, 8 ticks per NeoPixel bit.
- `syncReset`, input, 1: synchronous, active-high reset.
- `regCtrlRun`, input, 1: enables transmission.
- `regCtrlLoop`, input, 1: when 1, the next frame starts automatically after the latch period.
- `regCtrl32bit`, input, 1: selects addressing. 1 means 4 bytes per pixel; 0 means 1 byte per pixel.
- `regMax`, input, BUFFER_BITS: byte address of the last pixel to send.
- `state`, output, 1: `ENUM_STATE_RESET` or `ENUM_STATE_TRANSMIT`.
- `pixelIndex`, output, BUFFER_BITS: byte address of the current pixel.
- `pixelBitIndex`, output, 5: bit 0–23 within the current pixel.
- `bitPatternIndex`, output, 3: slot 0–7 within the current bit pattern.
- `streamSyncOf`, output, 1: one-cycle pulse on the last slot of a frame.

## Operation
- The FSM has two states, RESET and TRANSMIT. All outputs are registered.
- On `syncReset`:
  - `state` is RESET and all indexes are 0.
  - The delay counter is 0 and `streamSyncOf` is 0.
  - The frame-config latches are cleared.
- RESET state:
  - The delay counter increments each clock and saturates at `RESET_DELAY-1`.
  - Leave for TRANSMIT only when the counter is saturated and `regCtrlRun`=1. If the run condition is missing, stay in RESET with the counter saturated; a later rise of `regCtrlRun` then starts the frame on the next clock.
  - On entering TRANSMIT, latch `regMax` and `regCtrl32bit` into frame registers. Clear all indexes and the delay counter.
- TRANSMIT state, counter chain:
  - `bitPatternIndex` increments 0→7.
  - On 7, it wraps and `pixelBitIndex` increments 0→23.
  - On 23, it wraps and `pixelIndex` advances by 4 (32-bit mode, lower 2 bits forced 00) or by 1 (8-bit mode).
- End of frame:
  - Condition: `bitPatternIndex`=7, `pixelBitIndex`=23, and the current pixel is the last one.
  - Last pixel means `pixelIndex[BUFFER_BITS-1:2] >= maxLatched[BUFFER_BITS-1:2]` in 32-bit mode, or `pixelIndex >= maxLatched` in 8-bit mode.
  - Comparison is `>=`, so any wrap or overshoot ends the frame.
- At end of frame:
  - Pulse `streamSyncOf`.
  - Next cycle: go to RESET with indexes cleared and counter at 0.
  - If `regCtrlLoop`=0, the frame ends there. Software re-arms via `regCtrlRun`; the sequencer does not clear it. With run still 1 and loop 0, stay in RESET after the latch period.
- `regCtrlRun` falling mid-frame aborts the frame:
  - Next cycle: go to RESET, clear indexes, counter at 0, no `streamSyncOf`.
  - The full latch period is then enforced before any restart.
- `regMax` above `BUFFER_END` is clamped to `BUFFER_END` at latch time.
- Register changes during TRANSMIT have no effect until the next frame, except `regCtrlRun`.
- `syncReset` mid-frame behaves like the reset described above and takes priority over all other transitions.

## Timing
- Latency:
  - `regCtrlRun` rising with the counter saturated → `state`=TRANSMIT one clock later.
  - After `syncReset` is released, the first TRANSMIT is at the earliest `RESET_DELAY` clocks later.
- The first TRANSMIT cycle presents `pixelIndex`=0, `pixelBitIndex`=0, `bitPatternIndex`=0.
- Frame length is exactly N×192 clocks, where N = pixel count (`maxLatched`+1 in 8-bit mode, `maxLatched/4`+1 in 32-bit mode).
- `streamSyncOf` is high during the final slot cycle; `state`=RESET on the following cycle.
- Loop period is N×192 + `RESET_DELAY` clocks, with no extra idle cycles.

## Structure
- Add `RESET_DELAY_DEFAULT` to `anton_common.vh`, alongside `ENUM_STATE_RESET`/`ENUM_STATE_TRANSMIT`, `BUFFER_END_DEFAULT` and `CLOG2`. The state encoding must not be redefined locally.
- No sub-module. The index chain and delay counter are a single always block plus the FSM. The parent instantiates this block next to `anton_neopixel_stream`.

## Test plan
- **Reset then run:** release reset, `regCtrlRun`=1, `RESET_DELAY`=400 → `state`=TRANSMIT at clock 400 with all indexes 0.
- **8-bit frame:** `regMax`=2 → 576 TRANSMIT clocks; `pixelIndex` sequence 0,1,2; `streamSyncOf` pulses once at clock 575 of the frame; then RESET.
- **32-bit frame:** `regMax`=11 → `pixelIndex` sequence 0,4,8; 576 clocks; `pixelIndex[1:0]` always 00.
- **Loop:** `regCtrlLoop`=1, `regMax`=0 → frames of 192 clocks separated by exactly 400 RESET clocks, repeating.
- **Abort:** drop `regCtrlRun` at `pixelIndex`=1, `pixelBitIndex`=5 → RESET next clock, no `streamSyncOf`; re-raise run → restart only after 400 clocks.
- **Mid-frame config change and clamp:** change `regMax` 2→0 mid-frame → current frame still sends 3 pixels. Set `regMax`=`BUFFER_END`+5 (if representable) → clamped to `BUFFER_END`.
